// File: rtl/bcd_calendar_counter.sv
// BCD calendar counter: day/month/year in BCD, one day per advance strobe.
// Optional build macro: BCD_CAL_SATURATE_EN -- hold at 9999-12-31 instead of
// wrapping to 0000-01-01.
module bcd_calendar_counter #(
  parameter logic [3:0] RST_YM = 4'd2,
  parameter logic [3:0] RST_YH = 4'd0,
  parameter logic [3:0] RST_YT = 4'd0,
  parameter logic [3:0] RST_YO = 4'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  input  logic       load,
  input  logic [3:0] LdYM,
  input  logic [3:0] LdYH,
  input  logic [3:0] LdYT,
  input  logic [3:0] LdYO,
  output logic [3:0] YM,
  output logic [3:0] YH,
  output logic [3:0] YT,
  output logic [3:0] YO,
  output logic       MT,
  output logic [3:0] MO,
  output logic [1:0] DT,
  output logic [3:0] DO,
  output logic       LY,
  output logic       NewYear,
  output logic       LoadErr
);

  localparam int unsigned DigitW = 4;
  localparam logic [DigitW-1:0] Nine = 4'd9;

  // Two-digit BCD pair divisible by 4.
  function automatic logic div4(input logic [DigitW-1:0] tens, input logic [DigitW-1:0] ones);
    if (!tens[0]) return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    else          return (ones == 4'd2) || (ones == 4'd6);
  endfunction

  // Gregorian leap rule on BCD year digits.
  function automatic logic isLeap(input logic [DigitW-1:0] m, input logic [DigitW-1:0] h,
                                  input logic [DigitW-1:0] t, input logic [DigitW-1:0] o);
    if ((t == 4'd0) && (o == 4'd0)) return div4(m, h);
    else                            return div4(t, o);
  endfunction

  logic [DigitW-1:0] ymNext, yhNext, ytNext, yoNext, moNext, doNext;
  logic              mtNext, lyNext, newYearNext, loadErrNext;
  logic [1:0]        dtNext;
  logic [1:0]        lastDT;
  logic [DigitW-1:0] lastDO;
  logic              lastDay, lastMonth, ldValid;

  // Last day of the current month, as BCD tens/ones.
  always_comb begin
    lastDT = 2'd3;
    lastDO = 4'd1;
    if (!MT && (MO == 4'd2)) begin
      lastDT = 2'd2;
      lastDO = LY ? 4'd9 : 4'd8;
    end else if ((!MT && ((MO == 4'd4) || (MO == 4'd6) || (MO == 4'd9))) ||
                 (MT && (MO == 4'd1))) begin
      lastDO = 4'd0;
    end
  end

  assign lastDay   = (DT == lastDT) && (DO == lastDO);
  assign lastMonth = MT && (MO == 4'd2);
  assign ldValid   = (LdYM <= Nine) && (LdYH <= Nine) && (LdYT <= Nine) && (LdYO <= Nine);

  // Next-state: load beats advance; advance rolls day, month, then year.
  always_comb begin
    ymNext      = YM;
    yhNext      = YH;
    ytNext      = YT;
    yoNext      = YO;
    mtNext      = MT;
    moNext      = MO;
    dtNext      = DT;
    doNext      = DO;
    newYearNext = 1'b0;
    loadErrNext = 1'b0;
    if (load) begin
      if (ldValid) begin
        ymNext = LdYM;
        yhNext = LdYH;
        ytNext = LdYT;
        yoNext = LdYO;
        mtNext = 1'b0;
        moNext = 4'd1;
        dtNext = 2'd0;
        doNext = 4'd1;
      end else begin
        loadErrNext = 1'b1;
      end
    end else if (advance) begin
      if (!lastDay) begin
        if (DO == Nine) begin
          doNext = 4'd0;
          dtNext = 2'(DT + 2'd1);
        end else begin
          doNext = 4'(DO + 4'd1);
        end
      end else if (!lastMonth) begin
        dtNext = 2'd0;
        doNext = 4'd1;
        if (!MT && (MO == Nine)) begin
          mtNext = 1'b1;
          moNext = 4'd0;
        end else begin
          moNext = 4'(MO + 4'd1);
        end
      end else begin
`ifdef BCD_CAL_SATURATE_EN
        if (!((YM == Nine) && (YH == Nine) && (YT == Nine) && (YO == Nine))) begin
`else
        begin
`endif
          mtNext      = 1'b0;
          moNext      = 4'd1;
          dtNext      = 2'd0;
          doNext      = 4'd1;
          newYearNext = 1'b1;
          if (YO != Nine) yoNext = 4'(YO + 4'd1);
          else begin
            yoNext = 4'd0;
            if (YT != Nine) ytNext = 4'(YT + 4'd1);
            else begin
              ytNext = 4'd0;
              if (YH != Nine) yhNext = 4'(YH + 4'd1);
              else begin
                yhNext = 4'd0;
                ymNext = (YM == Nine) ? 4'd0 : 4'(YM + 4'd1);
              end
            end
          end
        end
      end
    end
    lyNext = isLeap(ymNext, yhNext, ytNext, yoNext);
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      YM      <= RST_YM;
      YH      <= RST_YH;
      YT      <= RST_YT;
      YO      <= RST_YO;
      MT      <= 1'b0;
      MO      <= 4'd1;
      DT      <= 2'd0;
      DO      <= 4'd1;
      LY      <= isLeap(RST_YM, RST_YH, RST_YT, RST_YO);
      NewYear <= 1'b0;
      LoadErr <= 1'b0;
    end else begin
      YM      <= ymNext;
      YH      <= yhNext;
      YT      <= ytNext;
      YO      <= yoNext;
      MT      <= mtNext;
      MO      <= moNext;
      DT      <= dtNext;
      DO      <= doNext;
      LY      <= lyNext;
      NewYear <= newYearNext;
      LoadErr <= loadErrNext;
    end
  end

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Bench for bcd_calendar_counter: directed vector table plus random traffic
// against an integer year/month/day reference model.
module tb_bcd_calendar_counter;

`ifdef BCD_CAL_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, advance, load;
  logic [3:0] LdYM, LdYH, LdYT, LdYO;
  logic [3:0] YM, YH, YT, YO, MO, DO;
  logic       MT, LY, NewYear, LoadErr;
  logic [1:0] DT;

  bcd_calendar_counter dut (
    .clock(clock), .reset(reset), .advance(advance), .load(load),
    .LdYM(LdYM), .LdYH(LdYH), .LdYT(LdYT), .LdYO(LdYO),
    .YM(YM), .YH(YH), .YT(YT), .YO(YO),
    .MT(MT), .MO(MO), .DT(DT), .DO(DO),
    .LY(LY), .NewYear(NewYear), .LoadErr(LoadErr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // Reference model state.
  int mYear, mMonth, mDay;
  bit mLY, mNY, mLE;

  function automatic bit leapOf(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int daysIn(int y, int m);
    case (m)
      2:            return leapOf(y) ? 29 : 28;
      4, 6, 9, 11:  return 30;
      default:      return 31;
    endcase
  endfunction

  function automatic logic [29:0] packExp(int y, int m, int d, bit ly, bit ny, bit le);
    return {4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10),
            1'(m / 10), 4'(m % 10), 2'(d / 10), 4'(d % 10), ly, ny, le};
  endfunction

  task automatic modelStep(input bit r, input bit l, input bit a, input logic [15:0] v);
    mNY = 1'b0;
    mLE = 1'b0;
    if (r) begin
      mYear = 2000; mMonth = 1; mDay = 1;
    end else if (l) begin
      if (v[15:12] > 9 || v[11:8] > 9 || v[7:4] > 9 || v[3:0] > 9) mLE = 1'b1;
      else begin
        mYear  = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
        mMonth = 1; mDay = 1;
      end
    end else if (a) begin
      if (mDay < daysIn(mYear, mMonth)) mDay++;
      else if (mMonth < 12) begin mMonth++; mDay = 1; end
      else if (!(Sat && mYear == 9999)) begin
        mMonth = 1; mDay = 1; mYear = (mYear + 1) % 10000; mNY = 1'b1;
      end
    end
    mLY = leapOf(mYear);
  endtask

  task automatic check(input string name, input logic [29:0] exp);
    logic [29:0] act;
    act = {YM, YH, YT, YO, MT, MO, DT, DO, LY, NewYear, LoadErr};
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit l, input bit a, input logic [15:0] v);
    reset = r; load = l; advance = a;
    {LdYM, LdYH, LdYT, LdYO} = v;
    @(posedge clock);
    #1;
    modelStep(r, l, a, v);
    check("model", packExp(mYear, mMonth, mDay, mLY, mNY, mLE));
  endtask

  typedef struct {
    bit          rst, ld, adv;
    logic [15:0] ldv;
    int          rep;
    int          y, m, d;
    bit          ly, ny, le;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input bit rst, input bit ld, input bit adv, input logic [15:0] ldv,
                        input int rep, input int y, input int m, input int d,
                        input bit ly, input bit ny, input bit le);
    vec_t t;
    t.rst = rst; t.ld = ld; t.adv = adv; t.ldv = ldv; t.rep = rep;
    t.y = y; t.m = m; t.d = d; t.ly = ly; t.ny = ny; t.le = le;
    vecs.push_back(t);
  endtask

  initial begin
    //     rst ld adv ldv      rep   year  m   d  LY NY LE
    addVec(1, 0, 0, 16'h0000,   1, 2000,  1,  1, 1, 0, 0);
    addVec(0, 0, 1, 16'h0000,  31, 2000,  2,  1, 1, 0, 0);
    addVec(0, 0, 1, 16'h0000,  28, 2000,  2, 29, 1, 0, 0);
    addVec(0, 0, 1, 16'h0000,   1, 2000,  3,  1, 1, 0, 0);
    addVec(0, 1, 0, 16'h1900,   1, 1900,  1,  1, 0, 0, 0);
    addVec(0, 0, 1, 16'h0000,  59, 1900,  3,  1, 0, 0, 0);
    addVec(0, 1, 0, 16'h1999,   1, 1999,  1,  1, 0, 0, 0);
    addVec(0, 0, 1, 16'h0000, 364, 1999, 12, 31, 0, 0, 0);
    addVec(0, 0, 1, 16'h0000,   1, 2000,  1,  1, 1, 1, 0);
    addVec(0, 0, 1, 16'h0000,   1, 2000,  1,  2, 1, 0, 0);
    addVec(0, 1, 0, 16'h9999,   1, 9999,  1,  1, 0, 0, 0);
    addVec(0, 0, 1, 16'h0000, 364, 9999, 12, 31, 0, 0, 0);
    if (Sat) addVec(0, 0, 1, 16'h0000, 1, 9999, 12, 31, 0, 0, 0);
    else     addVec(0, 0, 1, 16'h0000, 1,    0,  1,  1, 1, 1, 0);
    addVec(0, 1, 1, 16'h2024,   1, 2024,  1,  1, 1, 0, 0);
    addVec(0, 1, 0, 16'h20A4,   1, 2024,  1,  1, 1, 0, 1);
    addVec(0, 0, 1, 16'h0000,   1, 2024,  1,  2, 1, 0, 0);
    addVec(0, 0, 1, 16'h0000,  58, 2024,  2, 29, 1, 0, 0);
    addVec(1, 1, 1, 16'h1234,   1, 2000,  1,  1, 1, 0, 0);
    addVec(0, 1, 0, 16'hF000,   1, 2000,  1,  1, 1, 0, 1);
    addVec(0, 0, 0, 16'h0000,   3, 2000,  1,  1, 1, 0, 0);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].rep; k++)
        cycle(vecs[i].rst, vecs[i].ld, vecs[i].adv, vecs[i].ldv);
      check($sformatf("vec%0d", i),
            packExp(vecs[i].y, vecs[i].m, vecs[i].d, vecs[i].ly, vecs[i].ny, vecs[i].le));
    end

    // Hand sequence: reset in the middle of a run of advances.
    for (int k = 0; k < 40; k++) cycle(0, 0, 1, 16'h0000);
    cycle(1, 0, 1, 16'h0000);
    check("midReset", packExp(2000, 1, 1, 1, 0, 0));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      bit r, l, a;
      for (int n = 0; n < 4; n++)
        v[n*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      r = ($urandom_range(0, 1999) == 0);
      l = ($urandom_range(0, 399) == 0);
      a = ($urandom_range(0, 3) != 0);
      cycle(r, l, a, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
